// File: rtl/shift_add_mult_ctrl_pkg.sv
// Shared types and helpers for the shift-and-add multiplier controller:
// state encoding, counter sizing and the full-adder cell used by the ripple adder.
package shift_add_mult_ctrl_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ADD   = 2'd1,
    S_SHIFT = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam int DEFAULT_WIDTH = 4;

  // Step counter must hold 0..width-1; a 1-bit operand still needs a 1-bit counter.
  function automatic int cntWidth(input int w);
    if (w > 1) begin
      return $clog2(w);
    end else begin
      return 1;
    end
  endfunction

  // One full-adder cell: returns {carryOut, sum}.
  function automatic logic [1:0] fullAdd(input logic a, input logic b, input logic cin);
    logic s;
    logic c;
    s = a ^ b ^ cin;
    c = (a & b) | (cin & (a ^ b));
    return {c, s};
  endfunction

endpackage

// File: rtl/shift_add_mult_ctrl_adder.sv
// Combinational ripple-carry adder built from chained full-adder cells.
// Shared by the multiplier controller for every partial-product add.
module ripple_adder4
  import shift_add_mult_ctrl_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin
);

  logic [1:0] cell_s;
  logic       carry_s;

  // Walk the carry from bit 0 upward through one full-adder cell per bit.
  always_comb begin
    sum     = '0;
    cell_s  = 2'b00;
    carry_s = cin;
    for (int i = 0; i < WIDTH; i++) begin
      cell_s  = fullAdd(a[i], b[i], carry_s);
      sum[i]  = cell_s[0];
      carry_s = cell_s[1];
    end
    cout = carry_s;
  end

endmodule

// File: rtl/shift_add_mult_ctrl.sv
// Shift-and-add unsigned multiplier sequencer (A/Q/C algorithm) around one shared
// ripple adder, with a start/busy/done handshake and a held product register.
module shift_add_mult_ctrl
  import shift_add_mult_ctrl_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rstN,
  input  logic                 start,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int               CNT_W    = cntWidth(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_t               state_r;
  state_t               nextState_s;
  logic [WIDTH-1:0]     a_r;
  logic [WIDTH-1:0]     q_r;
  logic [WIDTH-1:0]     m_r;
  logic                 carry_r;
  logic [CNT_W-1:0]     cnt_r;
  logic [WIDTH-1:0]     sum_s;
  logic                 cout_s;
  logic                 busy_r;
  logic                 done_r;
  logic [2*WIDTH-1:0]   product_r;

  ripple_adder4 #(.WIDTH(WIDTH)) uAdder (
    .sum  (sum_s),
    .cout (cout_s),
    .a    (a_r),
    .b    (m_r),
    .cin  (1'b0)
  );

  // State register.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= nextState_s;
    end
  end

  // Next-state decode; start is only honoured in IDLE.
  always_comb begin
    nextState_s = S_IDLE;
    case (state_r)
      S_IDLE: begin
        if (start) begin
          nextState_s = S_ADD;
        end else begin
          nextState_s = S_IDLE;
        end
      end
      S_ADD:   nextState_s = S_SHIFT;
      S_SHIFT: begin
        if (cnt_r == CNT_LAST) begin
          nextState_s = S_DONE;
        end else begin
          nextState_s = S_ADD;
        end
      end
      S_DONE:  nextState_s = S_IDLE;
      default: nextState_s = S_IDLE;
    endcase
  end

  // Handshake flags are registered from the next state so they track state exactly.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      busy_r <= (nextState_s == S_ADD) || (nextState_s == S_SHIFT);
      done_r <= (nextState_s == S_DONE);
    end
  end

  // A/Q/M/C/cnt datapath and product capture.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      a_r       <= '0;
      q_r       <= '0;
      m_r       <= '0;
      carry_r   <= 1'b0;
      cnt_r     <= '0;
      product_r <= '0;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (start) begin
            m_r     <= multiplicand;
            q_r     <= multiplier;
            a_r     <= '0;
            carry_r <= 1'b0;
            cnt_r   <= '0;
          end else begin
            cnt_r   <= cnt_r;
          end
        end
        S_ADD: begin
          if (q_r[0]) begin
            a_r     <= sum_s;
            carry_r <= cout_s;
          end else begin
            carry_r <= 1'b0;
          end
        end
        S_SHIFT: begin
          a_r     <= {carry_r, a_r[WIDTH-1:1]};
          q_r     <= {a_r[0], q_r[WIDTH-1:1]};
          carry_r <= 1'b0;
          // Capture the final shifted {A,Q} now so product is valid alongside done.
          if (cnt_r == CNT_LAST) begin
            product_r <= {carry_r, a_r, q_r[WIDTH-1:1]};
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        S_DONE: begin
          cnt_r <= '0;
        end
        default: begin
          cnt_r <= '0;
        end
      endcase
    end
  end

  assign busy    = busy_r;
  assign done    = done_r;
  assign product = product_r;

endmodule

// File: tb/tb_shift_add_mult_ctrl.sv
// Directed, table-driven bench for shift_add_mult_ctrl (WIDTH=4) plus hand-written
// sequences for ignored starts, back-to-back operation and mid-operation reset.
module tb_shift_add_mult_ctrl;

  logic       clk;
  logic       rstN;
  logic       start;
  logic [3:0] multiplicand;
  logic [3:0] multiplier;
  logic       busy;
  logic       done;
  logic [7:0] product;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [3:0] m;
    logic [3:0] q;
    logic [7:0] expProduct;
  } vec_t;

  vec_t vecs[6];

  shift_add_mult_ctrl #(.WIDTH(4)) dut (
    .clk          (clk),
    .rstN         (rstN),
    .start        (start),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .busy         (busy),
    .done         (done),
    .product      (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // One full operation from IDLE: checks latency, busy length, product and single done.
  task automatic doOp(input logic [3:0] m, input logic [3:0] q, input logic [7:0] req,
                      input string tag);
    int cycles;
    int busyCnt;
    bit seen;
    @(negedge clk);
    start = 1'b1; multiplicand = m; multiplier = q;
    @(negedge clk);
    start = 1'b0;
    cycles = 0; busyCnt = 0; seen = 1'b0;
    while (!seen && cycles < 30) begin
      if (done) begin
        seen = 1'b1;
      end else begin
        if (busy) busyCnt++;
        cycles++;
        @(negedge clk);
      end
    end
    check({tag, "_done_seen"}, 32'(seen), 32'd1);
    check({tag, "_latency"}, 32'(cycles), 32'd8);
    check({tag, "_busy_cycles"}, 32'(busyCnt), 32'd8);
    check({tag, "_busy_in_done"}, 32'(busy), 32'd0);
    check({tag, "_product"}, 32'(product), 32'(req));
    @(negedge clk);
    check({tag, "_done_one_cycle"}, 32'(done), 32'd0);
    check({tag, "_product_held"}, 32'(product), 32'(req));
  endtask

  initial begin
    int doneCnt;
    int cyc;
    int lastDone;
    int op;
    logic [7:0] seenProduct;
    logic [3:0] b2bM[3];
    logic [3:0] b2bQ[3];
    logic [7:0] b2bP[3];

    vecs[0] = '{m: 4'd3,  q: 4'd5,  expProduct: 8'h0F};
    vecs[1] = '{m: 4'd1,  q: 4'd1,  expProduct: 8'h01};
    vecs[2] = '{m: 4'd15, q: 4'd1,  expProduct: 8'h0F};
    vecs[3] = '{m: 4'd10, q: 4'd12, expProduct: 8'h78};
    vecs[4] = '{m: 4'd1,  q: 4'd15, expProduct: 8'h0F};
    vecs[5] = '{m: 4'd8,  q: 4'd8,  expProduct: 8'h40};

    b2bM[0] = 4'd6;  b2bQ[0] = 4'd7;  b2bP[0] = 8'h2A;
    b2bM[1] = 4'd13; b2bQ[1] = 4'd11; b2bP[1] = 8'h8F;
    b2bM[2] = 4'd5;  b2bQ[2] = 4'd0;  b2bP[2] = 8'h00;

    rstN = 1'b0; start = 1'b0; multiplicand = 4'd0; multiplier = 4'd0;
    repeat (3) @(negedge clk);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_product", 32'(product), 32'd0);
    rstN = 1'b1;

    // Table of plain operations (first entry is the 3x5 reset-release case).
    for (int i = 0; i < 6; i++) begin
      doOp(vecs[i].m, vecs[i].q, vecs[i].expProduct, $sformatf("vec%0d", i));
    end

    // 15x15: carry out of the second add must land in C.
    @(negedge clk);
    start = 1'b1; multiplicand = 4'd15; multiplier = 4'd15;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    check("c15_first_add_carry", 32'(dut.carry_r), 32'd0);
    @(negedge clk);
    @(negedge clk);
    check("c15_second_add_carry", 32'(dut.carry_r), 32'd1);
    cyc = 0;
    while (!done && cyc < 20) begin
      cyc++;
      @(negedge clk);
    end
    check("c15_product", 32'(product), 32'h00E1);
    @(negedge clk);
    doOp(4'd15, 4'd15, 8'hE1, "full15");

    // Zero product must be held while idle, then 9x1.
    doOp(4'd0, 4'd7, 8'h00, "zero");
    repeat (3) begin
      @(negedge clk);
      check("zero_held_idle", 32'(product), 32'd0);
    end
    doOp(4'd9, 4'd1, 8'h09, "nine");

    // Start pulse while busy is ignored.
    @(negedge clk);
    start = 1'b1; multiplicand = 4'd2; multiplier = 4'd3;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    start = 1'b1; multiplicand = 4'd15; multiplier = 4'd15;
    @(negedge clk); start = 1'b0;
    doneCnt = 0; seenProduct = 8'h00;
    repeat (16) begin
      if (done) begin
        doneCnt++;
        seenProduct = product;
      end
      @(negedge clk);
    end
    check("ignored_start_done_count", 32'(doneCnt), 32'd1);
    check("ignored_start_product", 32'(seenProduct), 32'h0006);

    // start held high: operations back to back, operands scrambled mid-operation.
    start = 1'b1; multiplicand = b2bM[0]; multiplier = b2bQ[0];
    cyc = 0; lastDone = -1; op = 0;
    while (op < 3 && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (cyc == lastDone + 3 || (lastDone < 0 && cyc == 3)) begin
        multiplicand = 4'd15; multiplier = 4'd15;
      end
      if (done) begin
        check($sformatf("b2b%0d_product", op), 32'(product), 32'(b2bP[op]));
        if (op > 0) check($sformatf("b2b%0d_spacing", op), 32'(cyc - lastDone), 32'd10);
        lastDone = cyc;
        op++;
        if (op < 3) begin
          multiplicand = b2bM[op]; multiplier = b2bQ[op];
        end
      end
    end
    check("b2b_ops_completed", 32'(op), 32'd3);
    start = 1'b0;
    repeat (12) @(negedge clk);

    // Asynchronous reset between edges while in SHIFT aborts the operation.
    start = 1'b1; multiplicand = 4'd3; multiplier = 4'd5;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    check("abort_in_shift_busy", 32'(busy), 32'd1);
    #2 rstN = 1'b0;
    #1;
    check("abort_busy_drop", 32'(busy), 32'd0);
    check("abort_done_drop", 32'(done), 32'd0);
    check("abort_product_drop", 32'(product), 32'd0);
    @(negedge clk);
    rstN = 1'b1;
    doneCnt = 0;
    repeat (12) begin
      @(negedge clk);
      if (done) doneCnt++;
    end
    check("abort_no_done", 32'(doneCnt), 32'd0);
    doOp(4'd4, 4'd4, 8'h10, "after_abort");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
